// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the iterative integer square root.
// Holds the FSM state encoding and the iteration-count helper.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        DONE
    } state_t;

    function automatic int iter_count(input int n, input int bpc);
        return n / (2 * bpc);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root digit: shifts two operand bits into the
// remainder and resolves one root bit.
// Ports: rem_in/root_in (partial state in), two_bits (next operand pair),
//        rem_out/root_out (partial state out). Purely combinational.
module sqrt_step #(
    parameter int RW = 18
) (
    input  logic [RW-1:0] rem_in,
    input  logic [RW-3:0] root_in,
    input  logic [1:0]    two_bits,
    output logic [RW-1:0] rem_out,
    output logic [RW-3:0] root_out
);

    localparam int QW = RW - 2;

    logic [RW-1:0] rem_sh;
    logic [RW-1:0] trial;
    logic [RW-1:0] diff;
    logic          ge;

    // The two top remainder bits are always zero on entry; they only
    // give the trial compare headroom after the shift.
    logic unused_hi;
    assign unused_hi = ^rem_in[RW-1:RW-2];

    always_comb begin
        rem_sh   = {rem_in[QW-1:0], two_bits};
        trial    = {root_in, 2'b01};
        ge       = (rem_sh >= trial);
        diff     = rem_sh - trial;
        rem_out  = ge ? diff : rem_sh;
        root_out = {root_in[QW-2:0], ge};
    end

endmodule

// File: rtl/sqrt_iterative.sv
// Multi-cycle integer square root with valid/ready handshakes.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_number (signed x);
//        out_valid/out_ready/out_root/out_rem/out_neg (registered result).
module sqrt_iterative
    import sqrt_pkg::*;
#(
    parameter int N_BITS         = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter bit ROUND_NEAREST  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in_number,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS/2-1:0] out_root,
    output logic [N_BITS/2:0]   out_rem,
    output logic              out_neg
);

    localparam int RTW  = N_BITS / 2;
    localparam int RW   = RTW + 2;
    localparam int BPC  = BITS_PER_CYCLE;
    localparam int ITER = iter_count(N_BITS, BITS_PER_CYCLE);
    localparam int CW   = $clog2(ITER + 1);

    if ((N_BITS % 2) != 0 || N_BITS < 4) begin : g_bad_n
        $error("sqrt_iterative: N_BITS must be even and >= 4");
    end
    if (BPC != 1 && BPC != 2) begin : g_bad_bpc
        $error("sqrt_iterative: BITS_PER_CYCLE must be 1 or 2");
    end
    if ((RTW % BPC) != 0) begin : g_bad_div
        $error("sqrt_iterative: BITS_PER_CYCLE must divide N_BITS/2");
    end

    state_t            state_q, state_d;
    logic [N_BITS-1:0] op_q, op_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [RTW-1:0]    root_q, root_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [RTW-1:0]    oroot_q, oroot_d;
    logic [RTW:0]      orem_q, orem_d;
    logic              oneg_q, oneg_d;

    logic [BPC:0][RW-1:0]  rem_c;
    logic [BPC:0][RTW-1:0] root_c;
    logic                  round_up;

    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;

    // Operand pairs are consumed MSB first from the top of op_q.
    for (genvar i = 0; i < BPC; i++) begin : g_step
        sqrt_step #(.RW(RW)) u_step (
            .rem_in   (rem_c[i]),
            .root_in  (root_c[i]),
            .two_bits (op_q[N_BITS-1-2*i -: 2]),
            .rem_out  (rem_c[i+1]),
            .root_out (root_c[i+1])
        );
    end

    // Round up when x - r^2 > r, i.e. x lies past (r + 1/2)^2.
    assign round_up = ROUND_NEAREST && (rem_q > {2'b00, root_q});

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        oroot_d = oroot_q;
        orem_d  = orem_q;
        oneg_d  = oneg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    neg_d   = in_number[N_BITS-1];
                    op_d    = in_number[N_BITS-1] ? '0 : in_number;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d  = rem_c[BPC];
                root_d = root_c[BPC];
                op_d   = op_q << (2 * BPC);
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                oroot_d = neg_q ? '0 : (round_up ? root_q + RTW'(1) : root_q);
                orem_d  = neg_q ? '0 : rem_q[RTW:0];
                oneg_d  = neg_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            oroot_q <= '0;
            orem_q  <= '0;
            oneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            oroot_q <= oroot_d;
            orem_q  <= orem_d;
            oneg_q  <= oneg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_root  = oroot_q;
    assign out_rem   = orem_q;
    assign out_neg   = oneg_q;

endmodule

// File: tb/tb_sqrt_iterative.sv
// Scoreboard bench for sqrt_iterative: directed handshake/latency/reset
// cases on a 32-bit floor instance, plus sweeps over four configurations.
`timescale 1ns/1ps
module tb_sqrt_iterative;

    typedef struct {
        longint x;
        int     root;
        int     rem;
        bit     neg;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no event, expected one", nm);
    endtask

    function automatic void ref_sqrt(input longint x, input int nb, input bit rn,
                                     output int r, output int m, output bit ng);
        longint rr;
        longint t;
        rr = 0;
        if (x < 0) begin
            r = 0; m = 0; ng = 1'b1;
            return;
        end
        for (int b = nb / 2 - 1; b >= 0; b--) begin
            t = rr | (longint'(1) << b);
            if (t * t <= x) rr = t;
        end
        ng = 1'b0;
        m  = int'(x - rr * rr);
        r  = int'(rr);
        if (rn && m > r) r++;
    endfunction

    // Hand-computed table: x, floor root, remainder, nearest root.
    localparam int NV = 14;
    int tx[NV] = '{0, 1, 2, 3, 4, 15, 16, 17, 90, 99, 255, 256, 32767, -5};
    int tr[NV] = '{0, 1, 1, 1, 2, 3, 4, 4, 9, 9, 15, 16, 181, 0};
    int tm[NV] = '{0, 0, 1, 2, 0, 6, 0, 1, 9, 18, 30, 0, 6, 0};
    int tn[NV] = '{0, 1, 1, 2, 2, 4, 4, 4, 9, 10, 16, 16, 181, 0};

    // ---------------- main instance: N=32, BPC=1, floor ----------------
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_number;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_root;
    logic [16:0] out_rem;
    logic        out_neg;
    bit          mdone;

    sqrt_iterative #(
        .N_BITS(32), .BITS_PER_CYCLE(1), .ROUND_NEAREST(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_number(in_number),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_root(out_root), .out_rem(out_rem), .out_neg(out_neg)
    );

    vec_t mq[$];
    vec_t me;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (mq.size() == 0) begin
                fail("main unexpected result");
            end else begin
                me = mq.pop_front();
                chk($sformatf("main x=%0d root", me.x), out_root, me.root);
                chk($sformatf("main x=%0d rem", me.x), out_rem, me.rem);
                chk($sformatf("main x=%0d neg", me.x), out_neg, me.neg);
            end
        end
    end

    // Called at #1 after an edge; returns at #1 after the accepting edge.
    task automatic send_m(input logic [31:0] x, input int r, input int m,
                          input bit ng, input bit track);
        int   n;
        vec_t v;
        n = 0;
        in_valid  = 1'b1;
        in_number = x;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail("main accept timeout");
        end else if (track) begin
            v.x = longint'(signed'(x));
            v.root = r; v.rem = m; v.neg = ng;
            mq.push_back(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // k counts rising edges with the accepting edge as edge 1.
    task automatic wait_valid(input bit pulse, output int k);
        int bad;
        bad = 0;
        k = 1;
        while (!out_valid && k < 100) begin
            if (in_ready) bad++;
            if (pulse) begin
                in_valid  = (k >= 3 && k <= 5);
                in_number = 32'd12345;
            end
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!out_valid) fail("main out_valid timeout");
        if (pulse) chk("in_ready low while busy", bad, 0);
    endtask

    initial begin
        int          k;
        int          bad;
        int          n;
        logic [15:0] sr;
        logic [16:0] sm;
        rst_n = 1'b0; in_valid = 1'b0; in_number = '0; out_ready = 1'b1; mdone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_root", out_root, 0);
        chk("reset out_rem", out_rem, 0);
        chk("reset out_neg", out_neg, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_m(32'd0, 0, 0, 1'b0, 1'b1);
        wait_valid(1'b1, k);
        chk("latency x=0", k, 18);
        @(posedge clk); #1;
        send_m(32'd1, 1, 0, 1'b0, 1'b1);
        wait_valid(1'b0, k);
        chk("latency x=1", k, 18);
        @(posedge clk); #1;
        send_m(32'hFFFF_FFFB, 0, 0, 1'b1, 1'b1);
        wait_valid(1'b0, k);
        chk("latency x=-5", k, 18);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send_m(32'd99, 9, 18, 1'b0, 1'b1);
        wait_valid(1'b0, k);
        sr = out_root; sm = out_rem; bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || out_root !== sr || out_rem !== sm || out_neg)
                bad++;
        end
        chk("backpressure hold", bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid after handshake", out_valid, 0);
        chk("in_ready after handshake", in_ready, 1);

        send_m(32'h7FFF_FFFF, 46340, 88047, 1'b0, 1'b1);
        wait_valid(1'b0, k);
        @(posedge clk); #1;
        send_m(32'd90, 9, 9, 1'b0, 1'b1);
        wait_valid(1'b0, k);
        @(posedge clk); #1;

        send_m(32'd1000000, 1000, 0, 1'b0, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midreset in_ready", in_ready, 1);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset out_root", out_root, 0);
        chk("midreset out_rem", out_rem, 0);
        chk("midreset out_neg", out_neg, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_m(32'd16, 4, 0, 1'b0, 1'b1);
        wait_valid(1'b0, k);
        @(posedge clk); #1;

        n = 0;
        while (mq.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (mq.size() != 0) fail("main drain");
        mdone = 1'b1;
    end

    // ---------------- sweep instances ----------------
    localparam int CN[4] = '{32, 32, 16, 16};
    localparam int CB[4] = '{1, 2, 2, 1};
    localparam int CR[4] = '{1, 0, 1, 0};

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int NB = CN[g];
        localparam int BP = CB[g];
        localparam bit RN = (CR[g] != 0);

        logic          rst_n;
        logic          in_valid;
        logic          in_ready;
        logic [NB-1:0] in_number;
        logic          out_valid;
        logic          out_ready;
        logic [NB/2-1:0] out_root;
        logic [NB/2:0]   out_rem;
        logic          out_neg;
        bit            done;
        vec_t          q[$];
        vec_t          me;

        sqrt_iterative #(
            .N_BITS(NB), .BITS_PER_CYCLE(BP), .ROUND_NEAREST(RN)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready), .in_number(in_number),
            .out_valid(out_valid), .out_ready(out_ready),
            .out_root(out_root), .out_rem(out_rem), .out_neg(out_neg)
        );

        always @(negedge clk) begin
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail($sformatf("cfg%0d unexpected result", g));
                end else begin
                    me = q.pop_front();
                    chk($sformatf("cfg%0d x=%0d root", g, me.x), out_root, me.root);
                    chk($sformatf("cfg%0d x=%0d rem", g, me.x), out_rem, me.rem);
                    chk($sformatf("cfg%0d x=%0d neg", g, me.x), out_neg, me.neg);
                end
            end
        end

        initial begin
            out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end

        initial begin
            vec_t vs[$];
            vec_t v;
            int   n;
            rst_n = 1'b0; in_valid = 1'b0; in_number = '0; done = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int i = 0; i < NV; i++) begin
                v.x = tx[i];
                v.root = RN ? tn[i] : tr[i];
                v.rem = tm[i];
                v.neg = (tx[i] < 0);
                vs.push_back(v);
            end
            if (NB == 32) begin
                v.x = 2147483647;
                v.root = RN ? 46341 : 46340;
                v.rem = 88047;
                v.neg = 1'b0;
                vs.push_back(v);
            end
            for (int i = 0; i < 24; i++) begin
                v.x = longint'($urandom) & ((longint'(1) << (NB - 1)) - 1);
                if ($urandom_range(0, 7) == 0) v.x = -longint'($urandom_range(1, 1000));
                ref_sqrt(v.x, NB, RN, v.root, v.rem, v.neg);
                vs.push_back(v);
            end
            foreach (vs[i]) begin
                in_valid  = 1'b1;
                in_number = vs[i].x[NB-1:0];
                n = 0;
                @(negedge clk);
                while (!in_ready && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                if (!in_ready) fail($sformatf("cfg%0d accept timeout", g));
                else q.push_back(vs[i]);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            n = 0;
            while (q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
            if (q.size() != 0) fail($sformatf("cfg%0d drain", g));
            done = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(mdone && g_cfg[0].done && g_cfg[1].done && g_cfg[2].done
                 && g_cfg[3].done) && n < 40000) begin
            @(posedge clk);
            n++;
        end
        if (!(mdone && g_cfg[0].done && g_cfg[1].done && g_cfg[2].done
              && g_cfg[3].done))
            fail("global completion timeout");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
